// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//   SRAM-side responder for the SLC-3 memory bus.
//   Turns a CPU-side OE/WE request into a timed asynchronous SRAM cycle:
//     SETUP (1) -> ACCESS (WAIT_CYCLES) -> HOLD (1) -> IDLE.
//   Read data is captured into a holding register and a one-cycle Ready pulse
//   marks completion. Address 16'hFFFF is the I/O hole: the full sequence
//   runs but the chip is never selected, so the bridge can service it.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | chip deselected, waiting for an armed request
//   SETUP  | address/CE (and write data) driven, strobes still high
//   ACCESS | OE_N or WE_N low for WAIT_CYCLES cycles
//   HOLD   | strobes released, CE/address/data held, Ready pulsed
//
// Ports
//   Clk, Reset          : clock (rising edge), synchronous active-high reset
//   ADDR, OE, WE        : CPU request (WE wins over OE)
//   Data_to_SRAM        : CPU write data
//   Data_from_SRAM      : registered read data
//   Ready, Busy         : completion pulse, not-idle flag
//   SRAM_ADDR, SRAM_*_N : SRAM address and active-low controls
//   SRAM_DQ_I/_O/_T     : split SRAM data bus, _T = 1 drives the pins
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 20
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        ADDR,
    input  logic               OE,
    input  logic               WE,
    input  logic [15:0]        Data_to_SRAM,
    output logic [15:0]        Data_from_SRAM,
    output logic               Ready,
    output logic               Busy,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    input  logic [15:0]        SRAM_DQ_I,
    output logic [15:0]        SRAM_DQ_O,
    output logic               SRAM_DQ_T
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t             r_state;
    logic               r_armed;
    logic               r_write;
    logic               r_null;
    logic [3:0]         r_cnt;
    logic [15:0]        r_rdata;
    logic               r_ready;
    logic               r_busy;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_bank_n;
    logic [15:0]        r_dq_o;
    logic               r_dq_t;

    logic w_req;
    logic w_accept;
    logic w_null_in;

    assign w_req     = OE | WE;
    assign w_accept  = (r_state == ST_IDLE) && r_armed && w_req;
    assign w_null_in = (ADDR == 16'hFFFF);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b1;
            r_write     <= 1'b0;
            r_null      <= 1'b0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_bank_n    <= 1'b1;
            r_dq_o      <= '0;
            r_dq_t      <= 1'b0;
        end else begin
            // Re-arm only once the CPU has dropped both requests, so a request
            // held across completion cannot start a second access.
            if (!OE && !WE) begin
                r_armed <= 1'b1;
            end
            r_ready <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_armed     <= 1'b0;
                        r_state     <= ST_SETUP;
                        r_busy      <= 1'b1;
                        r_write     <= WE;
                        r_null      <= w_null_in;
                        r_cnt       <= LP_WAIT;
                        r_sram_addr <= SRAM_AW'(ADDR);
                        r_ce_n      <= w_null_in;
                        r_bank_n    <= 1'b0;
                        if (WE && !w_null_in) begin
                            r_dq_o <= Data_to_SRAM;
                            r_dq_t <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    if (!r_null) begin
                        r_oe_n <= r_write;
                        r_we_n <= !r_write;
                    end
                end

                ST_ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_HOLD;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ready <= 1'b1;
                        // Capture while OE_N is still low on this edge.
                        if (!r_write) begin
                            r_rdata <= r_null ? 16'h0000 : SRAM_DQ_I;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    // Data stays driven through HOLD for write hold time.
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_ce_n   <= 1'b1;
                    r_bank_n <= 1'b1;
                    r_dq_t   <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Data_from_SRAM = r_rdata;
    assign Ready          = r_ready;
    assign Busy           = r_busy;
    assign SRAM_ADDR      = r_sram_addr;
    assign SRAM_CE_N      = r_ce_n;
    assign SRAM_OE_N      = r_oe_n;
    assign SRAM_WE_N      = r_we_n;
    assign SRAM_UB_N      = r_bank_n;
    assign SRAM_LB_N      = r_bank_n;
    assign SRAM_DQ_O      = r_dq_o;
    assign SRAM_DQ_T      = r_dq_t;

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
//   Bench for sram_ctrl with an SRAM pin model, a transaction-level reference
//   (cycle offset since accept), per-cycle comparison, directed scenarios with
//   literal expectations and a randomized request phase.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk;
    logic          reset;
    logic [15:0]   addr;
    logic          oe;
    logic          we;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic          ready;
    logic          busy;
    logic [AW-1:0] sram_addr;
    logic          ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0]   dq_i;
    logic [15:0]   dq_o;
    logic          dq_t;

    sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .Clk            (clk),
        .Reset          (reset),
        .ADDR           (addr),
        .OE             (oe),
        .WE             (we),
        .Data_to_SRAM   (wdata),
        .Data_from_SRAM (rdata),
        .Ready          (ready),
        .Busy           (busy),
        .SRAM_ADDR      (sram_addr),
        .SRAM_CE_N      (ce_n),
        .SRAM_OE_N      (oe_n),
        .SRAM_WE_N      (we_n),
        .SRAM_UB_N      (ub_n),
        .SRAM_LB_N      (lb_n),
        .SRAM_DQ_I      (dq_i),
        .SRAM_DQ_O      (dq_o),
        .SRAM_DQ_T      (dq_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Unwritten locations read back as addr ^ 16'hACDB (0x1234 -> 0xBEEF).
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hACDB;
    endfunction

    // ---------------- SRAM pin model ----------------
    logic [15:0] sram_mem [0:65535];
    bit          sram_wr  [0:65535];
    logic [15:0] sa;
    assign sa   = sram_addr[15:0];
    assign dq_i = (!ce_n && !oe_n) ? (sram_wr[sa] ? sram_mem[sa] : init_val(sa)) : 16'hDEAD;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            sram_mem[sa] <= dq_t ? dq_o : 16'hDEAD;
            sram_wr[sa]  <= 1'b1;
        end
    end

    function automatic logic [15:0] sram_peek(input logic [15:0] a);
        return sram_wr[a] ? sram_mem[a] : init_val(a);
    endfunction

    // ---------------- reference model ----------------
    // m_k = cycles since accept (0 = idle). 1 setup, 2..W+1 strobe, W+2 ready.
    logic [15:0] ref_mem [0:65535];
    bit          ref_wr  [0:65535];
    int          m_k = 0;
    bit          m_armed = 1'b1;
    bit          m_write = 1'b0;
    bit          m_null = 1'b0;
    bit          m_acc;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_k     = 0;
            m_armed = 1'b1;
            m_rdata = '0;
        end else begin
            m_acc = (m_k == 0) && m_armed && (oe || we);
            if (!oe && !we) m_armed = 1'b1;
            if (m_k != 0) begin
                if (m_k == W + 1 && !m_write)
                    m_rdata = m_null ? 16'h0000 : (ref_wr[m_addr] ? ref_mem[m_addr] : init_val(m_addr));
                m_k = (m_k == W + 2) ? 0 : m_k + 1;
            end else if (m_acc) begin
                m_armed = 1'b0;
                m_write = we;
                m_addr  = addr;
                m_wdata = wdata;
                m_null  = (addr == 16'hFFFF);
                m_k     = 1;
                if (we && addr != 16'hFFFF) begin
                    ref_mem[addr] = wdata;
                    ref_wr[addr]  = 1'b1;
                end
            end
        end
        chk_en = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    bit e_act, e_strobe, e_dqt;
    always @(negedge clk) begin
        if (chk_en) begin
            e_act    = (m_k != 0);
            e_strobe = (m_k >= 2) && (m_k <= W + 1) && !m_null;
            e_dqt    = e_act && m_write && !m_null;
            chk("busy",  busy,  e_act);
            chk("ready", ready, m_k == W + 2);
            chk("ce_n",  ce_n,  !(e_act && !m_null));
            chk("oe_n",  oe_n,  !(e_strobe && !m_write));
            chk("we_n",  we_n,  !(e_strobe && m_write));
            chk("ub_n",  ub_n,  !e_act);
            chk("lb_n",  lb_n,  !e_act);
            chk("dq_t",  dq_t,  e_dqt);
            chk("rdata", rdata, m_rdata);
            if (e_dqt) chk("dq_o", dq_o, m_wdata);
            if (e_act) chk("sram_addr", sram_addr, {4'h0, m_addr});
        end
    end

    // ---------------- directed helpers ----------------
    bit          h_busy [0:31];
    bit          h_ready[0:31];
    bit          h_ce   [0:31];
    bit          h_oe   [0:31];
    bit          h_we   [0:31];
    bit          h_dqt  [0:31];
    logic [15:0] h_dqo  [0:31];
    logic [15:0] h_rd   [0:31];
    logic [19:0] h_addr [0:31];

    // Called at a negedge: drive request (sampled in cycle 0), record cycles
    // 1..ncyc, drop the request at cycle 'hold' and scramble ADDR/data.
    task automatic access(input logic w, input logic o, input logic [15:0] a,
                          input logic [15:0] d, input int hold, input int ncyc);
        we = w; oe = o; addr = a; wdata = d;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            h_busy[c] = busy;  h_ready[c] = ready; h_ce[c] = ce_n;
            h_oe[c]   = oe_n;  h_we[c]    = we_n;  h_dqt[c] = dq_t;
            h_dqo[c]  = dq_o;  h_rd[c]    = rdata; h_addr[c] = sram_addr;
            if (c == hold) begin
                oe = 1'b0; we = 1'b0;
                addr = 16'($urandom); wdata = 16'($urandom);
            end
        end
    endtask

    int pulses;
    int r;

    initial begin
        reset = 1'b1; oe = 1'b1; we = 1'b0; addr = 16'h0010; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst ce_n", ce_n, 1'b1);
        chk("rst oe_n", oe_n, 1'b1);
        chk("rst we_n", we_n, 1'b1);
        chk("rst ub_n", ub_n, 1'b1);
        chk("rst dq_t", dq_t, 1'b0);
        chk("rst ready", ready, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst rdata", rdata, 16'h0000);
        chk("rst addr", sram_addr, 20'h00000);
        reset = 1'b0;
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 1, 8);
        chk("post-rst busy c1", h_busy[1], 1'b1);
        chk("post-rst ready c4", h_ready[4], 1'b1);
        chk("post-rst rdata", h_rd[4], 16'hACCB);

        // read 0x1234 -> 0xBEEF
        access(1'b0, 1'b1, 16'h1234, 16'h0000, 1, 8);
        chk("rd addr", h_addr[1], 20'h01234);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("rd oe_n c%0d", c), h_oe[c], !(c == 2 || c == 3));
            chk($sformatf("rd ready c%0d", c), h_ready[c], c == 4);
            chk($sformatf("rd we_n c%0d", c), h_we[c], 1'b1);
            chk($sformatf("rd dq_t c%0d", c), h_dqt[c], 1'b0);
        end
        chk("rd data c4", h_rd[4], 16'hBEEF);
        chk("rd data c8", h_rd[8], 16'hBEEF);

        // write 0x00A5 <- 0x5A5A
        access(1'b1, 1'b0, 16'h00A5, 16'h5A5A, 1, 8);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("wr dq_t c%0d", c), h_dqt[c], c >= 1 && c <= 4);
            chk($sformatf("wr we_n c%0d", c), h_we[c], !(c == 2 || c == 3));
            chk($sformatf("wr oe_n c%0d", c), h_oe[c], 1'b1);
            if (c <= 4) chk($sformatf("wr dq_o c%0d", c), h_dqo[c], 16'h5A5A);
        end
        chk("wr mem", sram_peek(16'h00A5), 16'h5A5A);
        chk("wr rdata kept", h_rd[6], 16'hBEEF);

        // null read then null write
        access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1, 8);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("nrd ce_n c%0d", c), h_ce[c], 1'b1);
            chk($sformatf("nrd oe_n c%0d", c), h_oe[c], 1'b1);
            chk($sformatf("nrd ready c%0d", c), h_ready[c], c == 4);
        end
        chk("nrd rdata", h_rd[4], 16'h0000);
        access(1'b1, 1'b0, 16'hFFFF, 16'h1357, 1, 8);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("nwr ce_n c%0d", c), h_ce[c], 1'b1);
            chk($sformatf("nwr we_n c%0d", c), h_we[c], 1'b1);
            chk($sformatf("nwr dq_t c%0d", c), h_dqt[c], 1'b0);
            chk($sformatf("nwr ready c%0d", c), h_ready[c], c == 4);
        end

        // OE held 20 cycles -> one access
        access(1'b0, 1'b1, 16'h0042, 16'h0000, 20, 20);
        pulses = 0;
        for (int c = 1; c <= 20; c++) pulses += int'(h_ready[c]);
        chk("held oe pulses", pulses, 1);
        @(negedge clk);
        access(1'b0, 1'b1, 16'h0043, 16'h0000, 1, 8);
        chk("rearm busy c1", h_busy[1], 1'b1);
        chk("rearm ready c4", h_ready[4], 1'b1);

        // OE=WE=1 is a write
        access(1'b1, 1'b1, 16'h0077, 16'hC3C3, 1, 8);
        chk("both we_n c2", h_we[2], 1'b0);
        chk("both oe_n c2", h_oe[2], 1'b1);
        chk("both mem", sram_peek(16'h0077), 16'hC3C3);

        // reset during ACCESS of a write
        we = 1'b1; addr = 16'h0088; wdata = 16'h9999;
        @(negedge clk); we = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("mid-rst we_n", we_n, 1'b1);
        chk("mid-rst oe_n", oe_n, 1'b1);
        chk("mid-rst ce_n", ce_n, 1'b1);
        chk("mid-rst dq_t", dq_t, 1'b0);
        chk("mid-rst busy", busy, 1'b0);
        chk("mid-rst ready", ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid-rst no ready", ready, 1'b0);

        // randomized requests, checked every cycle against the model
        for (int i = 0; i < 2000; i++) begin
            r     = int'($urandom_range(0, 99));
            oe    = (r < 35);
            we    = (r >= 20 && r < 50);
            addr  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            wdata = 16'($urandom);
            @(negedge clk);
        end
        oe = 1'b0; we = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
